// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared state enum, opcode constants and width default for the M-extension sequencer
package mdu_pkg;

  localparam int MDU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - radix-2 multi-cycle multiply/divide unit for RV32M operations
module mul_div_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH,
  parameter int ITERATIONS = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  Start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Ready,
  output logic                  Stall,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITERATIONS + 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  step;
  logic [2:0]     op;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] acc;
  logic           neg_res;
  logic           neg_rem;

  // Operand classification, evaluated on the request lines for acceptance
  logic         accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic         div_zero, overflow, fast, last_step;
  logic [W-1:0] a_abs, b_abs, fast_result;

  assign accept    = (state == IDLE) && Start && !Flush;
  assign is_div    = Funct3[2];
  assign a_signed  = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
                     (Funct3 == F3_DIV)  || (Funct3 == F3_REM);
  assign b_signed  = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
  assign a_neg     = a_signed && SrcA[W-1];
  assign b_neg     = b_signed && SrcB[W-1];
  assign a_abs     = a_neg ? -SrcA : SrcA;
  assign b_abs     = b_neg ? -SrcB : SrcB;
  assign div_zero  = is_div && (SrcB == '0);
  assign overflow  = is_div && !Funct3[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
  assign fast      = div_zero || overflow;
  // Div-by-zero: quotient all ones, remainder = dividend. Overflow: quotient = dividend, remainder 0.
  assign fast_result = div_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);
  assign last_step = (step == CW'(ITERATIONS - 1));

  // One radix-2 step: acc holds {high/remainder, low/quotient}
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_next  = {mul_sum, acc[W-1:1]};
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, b_mag};
  assign div_ge    = !div_diff[W];
  assign div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc[W-2:0], div_ge};

  // Sign fix-up on the full product / quotient / remainder, then slice selection
  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_result;

  assign prod = neg_res ? -acc : acc;

  always_comb begin
    fix_result = '0;
    case (op)
      F3_MUL:                        fix_result = prod[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_result = prod[2*W-1:W];
      F3_DIV:                        fix_result = neg_res ? -acc[W-1:0] : acc[W-1:0];
      F3_DIVU:                       fix_result = acc[W-1:0];
      F3_REM:                        fix_result = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
      default:                       fix_result = acc[2*W-1:W];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; Flush overrides every transition
  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (Start) state_nxt = fast ? DONE : CALC;
        CALC:    if (last_step) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    Ready = (state == IDLE);
    Stall = (Start && Ready) || (state == CALC) || (state == FIX);
    Done  = (state == DONE) && !Flush;
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step    <= '0;
      op      <= '0;
      b_mag   <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      Result  <= '0;
    end else begin
      if (accept) begin
        op      <= Funct3;
        b_mag   <= b_abs;
        acc     <= {{W{1'b0}}, a_abs};
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        step    <= '0;
        if (fast) Result <= fast_result;
      end else if (state == CALC && !Flush) begin
        acc  <= op[2] ? div_next : mul_next;
        step <= last_step ? '0 : step + 1'b1;
      end else if (state == FIX && !Flush) begin
        Result <= fix_result;
      end
      if (Flush) step <= '0;
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - directed self-checking bench for mul_div_sequencer
module tb_mul_div_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Ready;
  logic        Stall;
  logic        Done;
  logic [31:0] Result;

  int checks   = 0;
  int failures = 0;

  mul_div_sequencer #(.DATA_WIDTH(32), .ITERATIONS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .Funct3  (Funct3),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .Flush   (Flush),
    .Ready   (Ready),
    .Stall   (Stall),
    .Done    (Done),
    .Result  (Result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, then count cycles after the acceptance edge until Done
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit seen;
    @(negedge clk);
    Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
    #1 check({tag, "_stall_req"}, Stall, 1);
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      Start = 1'b0;
      if (Done === 1'b1) seen = 1;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, Result, exp_res);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, Done, 0);
    check({tag, "_ready_after"}, Ready, 1);
    check({tag, "_result_hold"}, Result, exp_res);
  endtask

  initial begin
    int dcount;
    reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; Funct3 = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_ready", Ready, 1);
    check("reset_done", Done, 0);
    check("reset_result", Result, 0);
    check("reset_stall", Stall, 0);

    run_op("mul_7_m3",   F3_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulhu_m1",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulh_m1",    F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    run_op("mulhsu_m1",  F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("divu_zero",  F3_DIVU,   32'h12345678, 32'h0,        32'hFFFFFFFF, 1);
    run_op("remu_zero",  F3_REMU,   32'h12345678, 32'h0,        32'h12345678, 1);
    run_op("div_zero",   F3_DIV,    32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1);
    run_op("rem_zero",   F3_REM,    32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1);
    run_op("div_ovf",    F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",    F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("rem_m7_2",   F3_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34);
    run_op("div_m7_2",   F3_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34);
    run_op("divu_100_7", F3_DIVU,   32'd100,      32'd7,        32'd14,       34);
    run_op("remu_100_7", F3_REMU,   32'd100,      32'd7,        32'd2,        34);

    // Start held through DONE is ignored there and accepted in the following IDLE cycle
    @(negedge clk);
    Funct3 = F3_DIVU; SrcA = 32'h55; SrcB = 32'h0; Start = 1'b1;
    @(negedge clk);
    check("hold_done_first", Done, 1);
    check("hold_ready_in_done", Ready, 0);
    @(negedge clk);
    check("hold_no_accept_in_done", Done, 0);
    check("hold_idle_ready", Ready, 1);
    check("hold_idle_stall", Stall, 1);
    @(negedge clk);
    Start = 1'b0;
    check("hold_reaccept_done", Done, 1);
    @(negedge clk);

    // Flush and Start together in IDLE: flush wins
    Funct3 = F3_MUL; SrcA = 32'h3; SrcB = 32'h5; Start = 1'b1; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    #1 check("flush_start_ready", Ready, 1);
    check("flush_start_stall", Stall, 0);

    // Put a known value in Result, then flush a MUL at CALC cycle 10
    run_op("remu_pre", F3_REMU, 32'd100, 32'd7, 32'd2, 34);
    @(negedge clk);
    Funct3 = F3_MUL; SrcA = 32'h7; SrcB = 32'h9; Start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    Flush = 1'b1;
    #1 check("flush_calc_stall", Stall, 1);
    check("flush_calc_ready", Ready, 0);
    @(negedge clk);
    Flush = 1'b0;
    check("flush_idle", Ready, 1);
    check("flush_done", Done, 0);
    check("flush_result_kept", Result, 2);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done === 1'b1) dcount++;
    end
    check("flush_no_late_done", dcount, 0);
    run_op("mul_after_flush", F3_MUL, 32'h7, 32'h9, 32'd63, 34);

    // Reset at CALC cycle 10
    @(negedge clk);
    Funct3 = F3_MULHU; SrcA = 32'hFFFFFFFF; SrcB = 32'h2; Start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_calc_idle", Ready, 1);
    check("rst_calc_done", Done, 0);
    check("rst_calc_result", Result, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done === 1'b1) dcount++;
    end
    check("rst_no_late_done", dcount, 0);
    run_op("mulhu_after_rst", F3_MULHU, 32'hFFFFFFFF, 32'h2, 32'h1, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 The block SHALL have parameter ITERATIONS, default DATA_WIDTH, the number of radix-2 step cycles.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port Start, input, 1 bit: request valid for an M-extension operation.
REQ-007 The block SHALL have port Funct3, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 The block SHALL have ports SrcA and SrcB, inputs, DATA_WIDTH each: rs1 and rs2 operands.
REQ-009 The block SHALL have port Flush, input, 1 bit: abort the current operation.
REQ-010 The block SHALL have port Ready, output, 1 bit: high only in IDLE.
REQ-011 The block SHALL have port Stall, output, 1 bit: pipeline hold request.
REQ-012 The block SHALL have port Done, output, 1 bit: one-cycle result-valid pulse.
REQ-013 The block SHALL have port Result, output, DATA_WIDTH: the operation result.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX, DONE.
REQ-015 Start SHALL be accepted only when Start=1, the state is IDLE and Flush=0; on acceptance the block SHALL latch Funct3, SrcA and SrcB.
REQ-016 Start SHALL be ignored in every state other than IDLE.
REQ-017 On a normal acceptance the FSM SHALL go IDLE -> CALC; it SHALL stay in CALC for exactly ITERATIONS cycles, counted by a step counter that wraps to 0 on exit.
REQ-018 From CALC the FSM SHALL go to FIX for 1 cycle, then to DONE for 1 cycle, then back to IDLE.
REQ-019 Done SHALL be asserted in the DONE state only, ITERATIONS+2 cycles after the acceptance edge (34 cycles at the default).
REQ-020 Signed operands SHALL be converted to magnitudes at acceptance, and CALC SHALL run unsigned shift-add (multiply) or restoring shift-subtract (divide).
REQ-021 MULHSU SHALL treat SrcA as signed and SrcB as unsigned.
REQ-022 FIX SHALL apply sign correction to the full product before selecting the slice: the 2*DATA_WIDTH product is negated if the operand signs differ, then MUL* selects the low or high half.
REQ-023 In FIX, the quotient SHALL be negated if the signs differ, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero SHALL fast-path IDLE -> DONE, with Done asserted 1 cycle after acceptance.
  - DIV and DIVU SHALL return all ones.
  - REM and REMU SHALL return SrcA.
REQ-025 Signed overflow (DIV or REM with SrcA = most-negative value and SrcB = -1) SHALL fast-path IDLE -> DONE.
  - DIV SHALL return SrcA.
  - REM SHALL return 0.
REQ-026 Result SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next entry to DONE.
REQ-027 Ready SHALL be 1 in IDLE and 0 in CALC, FIX and DONE.
REQ-028 Stall SHALL be combinational and equal (Start AND Ready) OR the state being CALC or FIX, so that it holds the pipeline until the DONE cycle.
REQ-029 Flush=1 in any state SHALL force IDLE on the next edge, suppress Done and leave Result unchanged.
REQ-030 When Flush and Start are both 1 in IDLE, Flush SHALL win and the request SHALL not be accepted.
REQ-031 Start=1 during DONE SHALL not be accepted; the requester SHALL re-present Start in the following IDLE cycle.

Reset
REQ-032 While reset_n=0 at a clock edge, the block SHALL set state to IDLE, step counter to 0, Result to 0, Done to 0 and all internal operand and accumulator registers to 0.
REQ-033 Reset during CALC, FIX or DONE SHALL abort the operation with no Done pulse.
REQ-034 In the cycle after reset_n rises, Ready SHALL be 1.

Structure
REQ-035 A shared package mdu_pkg SHALL hold the state enum, the Funct3 opcode constants and the DATA_WIDTH default.
REQ-036 The implementation SHALL be a single module with no sub-module, and the datapath SHALL be inline in the module.

Verification
REQ-037 MUL with SrcA=7 and SrcB=0xFFFFFFFD SHALL give Result 0xFFFFFFEB, with Done exactly 34 cycles after acceptance.
REQ-038 MULHU with SrcA=SrcB=0xFFFFFFFF SHALL give Result 0xFFFFFFFE, and MULH with the same operands SHALL give 0x00000000.
REQ-039 Divide by zero with SrcA=0x12345678 SHALL give DIVU 0xFFFFFFFF and REMU 0x12345678, each with Done 1 cycle after acceptance.
REQ-040 Signed overflow with SrcA=0x80000000 and SrcB=0xFFFFFFFF SHALL give DIV 0x80000000 and REM 0, on the fast path.
REQ-041 REM with SrcA=0xFFFFFFF9 (-7) and SrcB=2 SHALL give 0xFFFFFFFF, and DIV with the same operands SHALL give 0xFFFFFFFD.
REQ-042 Flush at CALC cycle 10, and separately reset_n=0 at CALC cycle 10, SHALL each give state IDLE next cycle, no Done, and Result unchanged by the flush or 0 after the reset; a new Start SHALL then be accepted.
